// File: rtl/mem_bist_master_pkg.sv
// Shared types and helpers for the write-then-verify memory BIST master.
// Holds the run-sequencer state encoding and the address-derived test pattern.
package mem_bist_master_pkg;

    localparam int PAT_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Callers truncate the result to their data width, giving (seed + a) mod 2^WIDTH.
    function automatic logic [PAT_MAX-1:0] bist_pattern(input logic [PAT_MAX-1:0] seed,
                                                        input logic [PAT_MAX-1:0] a);
        return seed + a;
    endfunction

endpackage

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes (seed + addr) over an inclusive address range, reads it back,
// counts mismatches and reports pass/fail, range errors and ready timeouts.
module mem_bist_master
    import mem_bist_master_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic [WIDTH-1:0]      seed,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_rd,
    output logic [WIDTH-1:0]      w_data,
    output logic                  valid,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      r_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  range_err,
    output logic                  timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] start_q, start_n;
    logic [ADDR_WIDTH-1:0] end_q, end_n;
    logic [WIDTH-1:0]      seed_q, seed_n;
    logic [WAIT_W-1:0]     wait_cnt, wait_n;

    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  wr_rd_n;
    logic [WIDTH-1:0]      w_data_n;
    logic                  valid_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  pass_n;
    logic [ADDR_WIDTH:0]   err_n;
    logic [ADDR_WIDTH-1:0] first_n;
    logic                  range_n;
    logic                  timeout_n;

    logic [WIDTH-1:0]      pat_start;
    logic [WIDTH-1:0]      pat_cur;
    logic [WIDTH-1:0]      pat_next;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign addr_inc  = addr + ADDR_WIDTH'(1);
    assign pat_start = WIDTH'(bist_pattern(PAT_MAX'(seed), PAT_MAX'(start_addr)));
    assign pat_cur   = WIDTH'(bist_pattern(PAT_MAX'(seed_q), PAT_MAX'(addr)));
    assign pat_next  = WIDTH'(bist_pattern(PAT_MAX'(seed_q), PAT_MAX'(addr_inc)));

    always_comb begin
        state_n   = state_q;
        start_n   = start_q;
        end_n     = end_q;
        seed_n    = seed_q;
        wait_n    = wait_cnt;
        addr_n    = addr;
        wr_rd_n   = wr_rd;
        w_data_n  = w_data;
        valid_n   = valid;
        busy_n    = busy;
        done_n    = 1'b0;
        pass_n    = pass;
        err_n     = err_count;
        first_n   = first_err_addr;
        range_n   = range_err;
        timeout_n = timeout;

        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    start_n   = start_addr;
                    end_n     = end_addr;
                    seed_n    = seed;
                    wait_n    = '0;
                    err_n     = '0;
                    first_n   = '0;
                    pass_n    = 1'b0;
                    range_n   = 1'b0;
                    timeout_n = 1'b0;
                    if (start_addr > end_addr) begin
                        range_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n  = WRITE;
                        valid_n  = 1'b1;
                        busy_n   = 1'b1;
                        wr_rd_n  = 1'b1;
                        addr_n   = start_addr;
                        w_data_n = pat_start;
                    end
                end
            end

            WRITE, READ: begin
                if (valid && ready) begin
                    wait_n = '0;
                    if (state_q == READ && r_data != pat_cur) begin
                        if (err_count != '1)
                            err_n = err_count + (ADDR_WIDTH + 1)'(1);
                        if (err_count == '0)
                            first_n = addr;
                    end
                    // End check precedes the increment so end_addr = DEPTH-1 never wraps.
                    if (addr == end_q) begin
                        if (state_q == WRITE) begin
                            state_n = READ;
                            addr_n  = start_q;
                            wr_rd_n = 1'b0;
                        end else begin
                            state_n = DONE;
                            valid_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = (err_n == '0);
                        end
                    end else begin
                        addr_n = addr_inc;
                        if (state_q == WRITE)
                            w_data_n = pat_next;
                    end
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    state_n   = DONE;
                    valid_n   = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    timeout_n = 1'b1;
                    pass_n    = 1'b0;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            start_q        <= '0;
            end_q          <= '0;
            seed_q         <= '0;
            wait_cnt       <= '0;
            addr           <= '0;
            wr_rd          <= 1'b0;
            w_data         <= '0;
            valid          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            range_err      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state_q        <= state_n;
            start_q        <= start_n;
            end_q          <= end_n;
            seed_q         <= seed_n;
            wait_cnt       <= wait_n;
            addr           <= addr_n;
            wr_rd          <= wr_rd_n;
            w_data         <= w_data_n;
            valid          <= valid_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_err_addr <= first_n;
            range_err      <= range_n;
            timeout        <= timeout_n;
        end
    end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Parameter WIDTH, default 16, data width of the memory port.
REQ-002 Parameter DEPTH, default 16, number of memory locations.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 Parameter TIMEOUT, default 255, maximum wait cycles for ready per transfer.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  begin a write-then-verify run; sampled in IDLE only.
REQ-008 start_addr  input  ADDR_WIDTH  first address of run (inclusive).
REQ-009 end_addr  input  ADDR_WIDTH  last address of run (inclusive).
REQ-010 seed  input  WIDTH  pattern seed.
REQ-011 addr  output  ADDR_WIDTH  memory address.
REQ-012 wr_rd  output  1  1 = write, 0 = read.
REQ-013 w_data  output  WIDTH  write data.
REQ-014 valid  output  1  request valid.
REQ-015 ready  input  1  responder accepts request; for reads r_data is valid in the same cycle.
REQ-016 r_data  input  WIDTH  read data.
REQ-017 busy  output  1  run in progress.
REQ-018 done  output  1  one-cycle pulse at end of run.
REQ-019 pass  output  1  run completed with zero mismatches and no fault.
REQ-020 err_count  output  ADDR_WIDTH+1  read mismatches, saturating at all-ones.
REQ-021 first_err_addr  output  ADDR_WIDTH  address of first mismatch.
REQ-022 range_err  output  1  start_addr > end_addr on last start.
REQ-023 timeout  output  1  run aborted on ready timeout.

Function
REQ-024 All outputs SHALL be registered.
REQ-025 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-026 IDLE: valid=0, busy=0; start=1 SHALL clear err_count, first_err_addr, pass, range_err, timeout, and latch start_addr, end_addr and seed.
REQ-027 Start with start_addr > end_addr SHALL go to DONE with range_err=1, pass=0, and no valid asserted.
REQ-028 Otherwise the FSM SHALL go to WRITE; valid=1, wr_rd=1, addr=start_addr in the next cycle.
REQ-029 Pattern for address a SHALL be (seed + a) mod 2^WIDTH.
REQ-030 A transfer completes on a rising edge with valid=1 and ready=1; until then addr, wr_rd and w_data SHALL stay stable.
REQ-031 After a completed transfer, valid SHALL remain 1 with the next address (back-to-back, no idle cycle), including the WRITE->READ switch.
REQ-032 WRITE: completion at end_addr SHALL move to READ with addr=start_addr and wr_rd=0.
REQ-033 READ: on completion, r_data != pattern(addr) SHALL increment err_count (saturating); the first mismatch SHALL latch first_err_addr.
REQ-034 READ: completion at end_addr SHALL move to DONE.
REQ-035 The address counter SHALL compare against end_addr before incrementing; end_addr=DEPTH-1 SHALL NOT wrap or overrun.
REQ-036 A per-transfer wait counter SHALL abort to DONE with timeout=1 when ready has been low for TIMEOUT+1 consecutive valid cycles.
REQ-037 DONE: valid=0, done=1 for exactly one cycle, pass=(err_count==0 && !timeout && !range_err), then IDLE.
REQ-038 pass, err_count, first_err_addr, range_err and timeout SHALL hold until the next accepted start.
REQ-039 start while busy SHALL be ignored.

Reset
REQ-040 rst=0 at a rising edge SHALL force IDLE and clear all outputs and counters to 0 in that cycle, including mid-transfer (valid drops without completion).

Structure
REQ-041 A shared package SHALL hold the FSM state enum and the pattern function.
REQ-042 Single module; no sub-module.

Verification
REQ-043 Range 0..15, seed 16'hA5A5, ready tied 1 -> writes 0..15 with data A5A5..A5B4, 16 reads, done in the 34th cycle after start, pass=1, err_count=0.
REQ-044 Responder stalls ready randomly 0-3 cycles -> addr, wr_rd and w_data stable during stalls; same results as REQ-043.
REQ-045 Responder corrupts r_data at addresses 5 and 9 -> err_count=2, first_err_addr=5, pass=0.
REQ-046 start_addr=7, end_addr=7 -> one write and one read, pass=1; start_addr=10, end_addr=3 -> done after one cycle, range_err=1, valid never 1.
REQ-047 ready held 0 -> done 256 cycles after valid rises, timeout=1, pass=0.
REQ-048 rst=0 during READ -> valid=0 and busy=0 the next cycle; start pulsed while busy has no effect.
